pipe_ctrl: RTL

Central stall/flush sequencer for the five-stage pipeline. It generates the per-stage load enables that freeze or advance the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB), and the flush strobes that turn instructions into bubbles. It tracks which instruction- and data-memory responses have arrived, detects load-use hazards, and squashes wrong-path instructions on a taken branch. It sits beside the datapath and drives the `load` and `reset`/flush inputs of every pipeline register.

---
 rtl/pipe_ctrl_if.sv | 52 +++++
 rtl/pipe_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle of the memory-response, hazard-detection and
// pipeline-register control signals exchanged between the datapath and
// the stall/flush sequencer.
//
// Handshake: imem_resp and dmem_resp are single-cycle "complete" strobes.
// The sequencer captures a strobe that arrives while the other side is
// still busy. A response is consumed on the advance edge, which is the
// edge where all load enables that are allowed to rise are high. The
// memory side must not repeat a captured response.
interface pipe_ctrl_if #(parameter int REG_W = 5);
    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_is_load;
    logic             ex_branch_taken;
    logic             load_pc;
    logic             load_if_id;
    logic             load_id_ex;
    logic             load_ex_mem;
    logic             load_mem_wb;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [1:0]       stall_state;
    logic [31:0]      perf_stall;
    logic [31:0]      perf_bubble;
    logic [31:0]      perf_flush;

    // Datapath / memory side
    modport master (
        output imem_resp, dmem_req, dmem_resp,
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_is_load, ex_branch_taken,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
        input  flush_if_id, flush_id_ex, stall_state,
        input  perf_stall, perf_bubble, perf_flush
    );

    // Sequencer side
    modport slave (
        input  imem_resp, dmem_req, dmem_resp,
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_is_load, ex_branch_taken,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
        output flush_if_id, flush_id_ex, stall_state,
        output perf_stall, perf_bubble, perf_flush
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the five-stage pipeline.
// It produces the per-stage load enables and the bubble/squash flush strobes.
// It also remembers memory responses that arrive before the pipeline can advance.
// Optional feature macro: PIPE_CTRL_PERF_EN. When it is defined, the
// stall/bubble/flush performance counters are live. When it is undefined,
// the counters are not built and the outputs are tied to 0.
module pipe_ctrl #(
    parameter int REG_W = 5
) (
    input logic       clk,
    input logic       reset,   // asynchronous, active-low
    pipe_ctrl_if.slave bus
);

    localparam logic [REG_W-1:0] ZERO_IDX = '0;

    logic i_done_q, d_done_q;
    logic i_done_d, d_done_d;
    logic i_ok, d_ok, advance, hazard;
    logic [4:0] loads;     // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0] flushes;   // {if_id, id_ex}
    logic stall_ev, bubble_ev, flush_ev;

    // Response bookkeeping, hazard detection and load/flush generation
    always_comb begin
        i_ok    = bus.imem_resp | i_done_q;
        d_ok    = ~bus.dmem_req | bus.dmem_resp | d_done_q;
        advance = i_ok & d_ok;
        hazard  = bus.ex_is_load & (bus.ex_rd != ZERO_IDX) &
                  ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                   (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

        i_done_d  = i_done_q;
        d_done_d  = d_done_q;
        loads     = 5'b00000;
        flushes   = 2'b00;
        stall_ev  = 1'b0;
        bubble_ev = 1'b0;
        flush_ev  = 1'b0;

        if (advance) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end else begin
            // Responses without a matching outstanding access are ignored.
            if (bus.imem_resp)                 i_done_d = 1'b1;
            if (bus.dmem_req && bus.dmem_resp) d_done_d = 1'b1;
        end

        if (reset) begin
            if (!advance) begin
                stall_ev = 1'b1;
            end else if (bus.ex_branch_taken) begin
                // The branch wins over the hazard because the hazard
                // consumer is on the wrong path and is squashed anyway.
                loads    = 5'b11111;
                flushes  = 2'b11;
                flush_ev = 1'b1;
            end else if (hazard) begin
                // Freeze PC and IF/ID, and insert a bubble into ID/EX.
                loads     = 5'b00111;
                flushes   = 2'b01;
                bubble_ev = 1'b1;
            end else begin
                loads = 5'b11111;
            end
        end
    end

    // Early-response flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_bubble_q, perf_flush_q;

    // Event counters that wrap modulo 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (stall_ev)  perf_stall_q  <= perf_stall_q + 32'd1;
            if (bubble_ev) perf_bubble_q <= perf_bubble_q + 32'd1;
            if (flush_ev)  perf_flush_q  <= perf_flush_q + 32'd1;
        end
    end

    assign bus.perf_stall  = perf_stall_q;
    assign bus.perf_bubble = perf_bubble_q;
    assign bus.perf_flush  = perf_flush_q;
`else
    // Without counters, the event strobes have no consumer.
    logic unused_ev;
    assign unused_ev       = stall_ev ^ bubble_ev ^ flush_ev;
    assign bus.perf_stall  = '0;
    assign bus.perf_bubble = '0;
    assign bus.perf_flush  = '0;
`endif

    assign {bus.load_pc, bus.load_if_id, bus.load_id_ex,
            bus.load_ex_mem, bus.load_mem_wb} = loads;
    assign {bus.flush_if_id, bus.flush_id_ex} = flushes;
    assign bus.stall_state = {~d_ok, ~i_ok};

endmodule
